// File: rtl/alu_rr_sequencer.sv
// ----------------------------------------------------------------------------
// alu_rr_sequencer
//   Steps one RV32I R-type instruction at a time through the ALU:
//   handshake -> register-file read -> operand capture -> ALU execute -> write.
//
//   Optional build macro: ALU_RR_ILLEGAL_TRAP_EN
//     defined   : illegal encodings skip the RF read, pulse o_illegal_instr
//                 during the READ cycle and return to IDLE without a write.
//     undefined : o_illegal_instr tied 0, no opcode check, unknown funct7
//                 executes on the base ALU.
//
// Ports
//   i_clock, i_reset_n              clock, async active-low reset
//   i_instr_valid/o_instr_ready     instruction handshake, i_instr word
//   o_rf_read_enable, o_rf_rs*_addr register-file read port, i_rf_rs*_data
//   o_alu_*                         ALU operands, funct3, base/extra enables
//   i_alu_result(_valid)            ALU result return
//   o_rf_write_enable, o_rf_rd_*    register-file write port
//   o_busy, o_timeout_error, o_illegal_instr  status
// ----------------------------------------------------------------------------
// state     | meaning
// S_IDLE    | ready for a new instruction
// S_READ    | RF read strobe (or illegal trap)
// S_CAPTURE | register RF data into ALU operands
// S_EXEC    | ALU enabled, waiting for result or timeout
// S_WB      | write strobe to rd (suppressed for x0)
// ----------------------------------------------------------------------------
module alu_rr_sequencer #(
  parameter int unsigned ALU_TIMEOUT = 15
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_instr_valid,
  output logic        o_instr_ready,
  input  logic [31:0] i_instr,
  output logic        o_rf_read_enable,
  output logic [4:0]  o_rf_rs1_addr,
  output logic [4:0]  o_rf_rs2_addr,
  input  logic [31:0] i_rf_rs1_data,
  input  logic [31:0] i_rf_rs2_data,
  output logic [31:0] o_alu_operand_a,
  output logic [31:0] o_alu_operand_b,
  output logic [2:0]  o_alu_funct3,
  output logic        o_alu_base_enable,
  output logic        o_alu_extra_enable,
  input  logic [31:0] i_alu_result,
  input  logic        i_alu_result_valid,
  output logic        o_rf_write_enable,
  output logic [4:0]  o_rf_rd_addr,
  output logic [31:0] o_rf_rd_data,
  output logic        o_busy,
  output logic        o_timeout_error,
  output logic        o_illegal_instr
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_EXEC    = 3'd3,
    S_WB      = 3'd4
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(ALU_TIMEOUT);

  state_t      r_state;
  logic [6:0]  r_funct7;
  logic [4:0]  r_rs2;
  logic [4:0]  r_rs1;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic [31:0] r_operand_a;
  logic [31:0] r_operand_b;
  logic [31:0] r_rd_data;
  logic [7:0]  r_timer;
  logic        r_instr_ready;
  logic        r_rf_read_enable;
  logic        r_rf_write_enable;
  logic        r_base_enable;
  logic        r_extra_enable;
  logic        r_timeout_error;
  logic        r_illegal_instr;

  logic        w_illegal;
  logic [7:0]  w_timer_next;

  // Decode happens on the incoming word at the handshake so that the READ
  // cycle can already suppress the RF strobe.
`ifdef ALU_RR_ILLEGAL_TRAP_EN
  always_comb begin
    w_illegal = 1'b0;
    if (i_instr[6:0] != 7'h33)
      w_illegal = 1'b1;
    else if ((i_instr[31:25] != 7'h00) && (i_instr[31:25] != 7'h20))
      w_illegal = 1'b1;
    else if ((i_instr[31:25] == 7'h20) &&
             (i_instr[14:12] != 3'b000) && (i_instr[14:12] != 3'b101))
      w_illegal = 1'b1;
  end
  assign o_illegal_instr = r_illegal_instr;
`else
  logic w_unused_opcode;
  assign w_unused_opcode = ^i_instr[6:0];
  assign w_illegal       = 1'b0;
  assign o_illegal_instr = 1'b0;
`endif

  assign w_timer_next = r_timer + 8'd1;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state           <= S_IDLE;
      r_funct7          <= '0;
      r_rs2             <= '0;
      r_rs1             <= '0;
      r_funct3          <= '0;
      r_rd              <= '0;
      r_operand_a       <= '0;
      r_operand_b       <= '0;
      r_rd_data         <= '0;
      r_timer           <= '0;
      r_instr_ready     <= 1'b1;
      r_rf_read_enable  <= 1'b0;
      r_rf_write_enable <= 1'b0;
      r_base_enable     <= 1'b0;
      r_extra_enable    <= 1'b0;
      r_timeout_error   <= 1'b0;
      r_illegal_instr   <= 1'b0;
    end else begin
      // single-cycle strobes
      r_rf_read_enable  <= 1'b0;
      r_rf_write_enable <= 1'b0;
      r_timeout_error   <= 1'b0;
      r_illegal_instr   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_instr_valid) begin
            r_funct7         <= i_instr[31:25];
            r_rs2            <= i_instr[24:20];
            r_rs1            <= i_instr[19:15];
            r_funct3         <= i_instr[14:12];
            r_rd             <= i_instr[11:7];
            r_instr_ready    <= 1'b0;
            r_rf_read_enable <= ~w_illegal;
            r_illegal_instr  <= w_illegal;
            r_state          <= S_READ;
          end
        end

        S_READ: begin
          if (r_illegal_instr) begin
            r_instr_ready <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_state <= S_CAPTURE;
          end
        end

        S_CAPTURE: begin
          r_operand_a    <= i_rf_rs1_data;
          r_operand_b    <= i_rf_rs2_data;
          r_timer        <= '0;
          // anything other than 7'h20 runs on the base ALU
          r_extra_enable <= (r_funct7 == 7'h20);
          r_base_enable  <= (r_funct7 != 7'h20);
          r_state        <= S_EXEC;
        end

        S_EXEC: begin
          // a result arriving in the terminal cycle takes priority
          if (i_alu_result_valid) begin
            r_rd_data         <= i_alu_result;
            r_base_enable     <= 1'b0;
            r_extra_enable    <= 1'b0;
            r_rf_write_enable <= (r_rd != 5'd0);
            r_state           <= S_WB;
          end else if (w_timer_next == TIMEOUT_CNT) begin
            r_timer         <= w_timer_next;
            r_timeout_error <= 1'b1;
            r_base_enable   <= 1'b0;
            r_extra_enable  <= 1'b0;
            r_instr_ready   <= 1'b1;
            r_state         <= S_IDLE;
          end else begin
            r_timer <= w_timer_next;
          end
        end

        S_WB: begin
          r_instr_ready <= 1'b1;
          r_state       <= S_IDLE;
        end

        default: begin
          r_base_enable  <= 1'b0;
          r_extra_enable <= 1'b0;
          r_instr_ready  <= 1'b1;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

  assign o_instr_ready      = r_instr_ready;
  assign o_busy             = ~r_instr_ready;
  assign o_rf_read_enable   = r_rf_read_enable;
  assign o_rf_rs1_addr      = r_rs1;
  assign o_rf_rs2_addr      = r_rs2;
  assign o_alu_operand_a    = r_operand_a;
  assign o_alu_operand_b    = r_operand_b;
  assign o_alu_funct3       = r_funct3;
  assign o_alu_base_enable  = r_base_enable;
  assign o_alu_extra_enable = r_extra_enable;
  assign o_rf_write_enable  = r_rf_write_enable;
  assign o_rf_rd_addr       = r_rd;
  assign o_rf_rd_data       = r_rd_data;
  assign o_timeout_error    = r_timeout_error;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
module tb_alu_rr_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic        rf_read_enable;
  logic [4:0]  rf_rs1_addr;
  logic [4:0]  rf_rs2_addr;
  logic [31:0] rf_rs1_data = 32'd5;
  logic [31:0] rf_rs2_data = 32'd7;
  logic [31:0] alu_operand_a;
  logic [31:0] alu_operand_b;
  logic [2:0]  alu_funct3;
  logic        alu_base_enable;
  logic        alu_extra_enable;
  logic [31:0] alu_result = '0;
  logic        alu_result_valid = 1'b0;
  logic        rf_write_enable;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        busy;
  logic        timeout_error;
  logic        illegal_instr;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  alu_rr_sequencer #(.ALU_TIMEOUT(15)) dut (
    .i_clock            (clock),
    .i_reset_n          (reset_n),
    .i_instr_valid      (instr_valid),
    .o_instr_ready      (instr_ready),
    .i_instr            (instr),
    .o_rf_read_enable   (rf_read_enable),
    .o_rf_rs1_addr      (rf_rs1_addr),
    .o_rf_rs2_addr      (rf_rs2_addr),
    .i_rf_rs1_data      (rf_rs1_data),
    .i_rf_rs2_data      (rf_rs2_data),
    .o_alu_operand_a    (alu_operand_a),
    .o_alu_operand_b    (alu_operand_b),
    .o_alu_funct3       (alu_funct3),
    .o_alu_base_enable  (alu_base_enable),
    .o_alu_extra_enable (alu_extra_enable),
    .i_alu_result       (alu_result),
    .i_alu_result_valid (alu_result_valid),
    .o_rf_write_enable  (rf_write_enable),
    .o_rf_rd_addr       (rf_rd_addr),
    .o_rf_rd_data       (rf_rd_data),
    .o_busy             (busy),
    .o_timeout_error    (timeout_error),
    .o_illegal_instr    (illegal_instr)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  // Presents the word in cycle 0 and returns positioned in cycle 1.
  task automatic issue(input string tag, input logic [31:0] word);
    chk({tag, "_ready_c0"}, 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr       = word;
    step();
    instr_valid = 1'b0;
    instr       = 32'hFFFF_FFFF;
  endtask

  initial begin
    // ---------------- reset ----------------
    step();
    chk("rst_ready",   32'(instr_ready),      32'd1);
    chk("rst_busy",    32'(busy),             32'd0);
    chk("rst_rden",    32'(rf_read_enable),   32'd0);
    chk("rst_wren",    32'(rf_write_enable),  32'd0);
    chk("rst_base",    32'(alu_base_enable),  32'd0);
    chk("rst_extra",   32'(alu_extra_enable), 32'd0);
    chk("rst_opa",     alu_operand_a,         32'd0);
    chk("rst_rdaddr",  32'(rf_rd_addr),       32'd0);
    chk("rst_tmo",     32'(timeout_error),    32'd0);
    chk("rst_ill",     32'(illegal_instr),    32'd0);
    reset_n = 1'b1;
    step();

    // ---------------- ADD x3,x1,x2 ----------------
    issue("add", rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3));
    chk("add_rden_c1", 32'(rf_read_enable), 32'd1);
    chk("add_rs1",     32'(rf_rs1_addr),    32'd1);
    chk("add_rs2",     32'(rf_rs2_addr),    32'd2);
    chk("add_busy_c1", 32'(busy),           32'd1);
    alu_result_valid = 1'b1;               // outside EXEC: must be ignored
    alu_result       = 32'd99;
    step();
    alu_result_valid = 1'b0;
    chk("add_rden_c2", 32'(rf_read_enable),  32'd0);
    chk("add_base_c2", 32'(alu_base_enable), 32'd0);
    step();
    chk("add_base_c3",  32'(alu_base_enable),  32'd1);
    chk("add_extra_c3", 32'(alu_extra_enable), 32'd0);
    chk("add_opa",      alu_operand_a,         32'd5);
    chk("add_opb",      alu_operand_b,         32'd7);
    chk("add_f3",       32'(alu_funct3),       32'd0);
    chk("add_wren_c3",  32'(rf_write_enable),  32'd0);
    alu_result_valid = 1'b1;
    alu_result       = 32'd12;
    step();
    alu_result_valid = 1'b0;
    chk("add_wren_c4", 32'(rf_write_enable),  32'd1);
    chk("add_rd",      32'(rf_rd_addr),       32'd3);
    chk("add_data",    rf_rd_data,            32'd12);
    chk("add_base_c4", 32'(alu_base_enable),  32'd0);
    step();
    chk("add_wren_c5",  32'(rf_write_enable), 32'd0);
    chk("add_ready_c5", 32'(instr_ready),     32'd1);

    // ---------------- SUB x4,x1,x2, result one cycle late ----------------
    issue("sub", rtype(7'h20, 5'd2, 5'd1, 3'b000, 5'd4));
    step();
    step();
    chk("sub_extra_c3", 32'(alu_extra_enable), 32'd1);
    chk("sub_base_c3",  32'(alu_base_enable),  32'd0);
    step();
    chk("sub_extra_c4", 32'(alu_extra_enable), 32'd1);
    chk("sub_base_c4",  32'(alu_base_enable),  32'd0);
    chk("sub_opa_c4",   alu_operand_a,         32'd5);
    chk("sub_wren_c4",  32'(rf_write_enable),  32'd0);
    alu_result_valid = 1'b1;
    alu_result       = 32'hFFFF_FFFE;
    step();
    alu_result_valid = 1'b0;
    chk("sub_wren",  32'(rf_write_enable),  32'd1);
    chk("sub_rd",    32'(rf_rd_addr),       32'd4);
    chk("sub_data",  rf_rd_data,            32'hFFFF_FFFE);
    chk("sub_extra", 32'(alu_extra_enable), 32'd0);
    step();
    chk("sub_ready", 32'(instr_ready), 32'd1);

    // ---------------- ADD x0,x1,x2 ----------------
    issue("x0", rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd0));
    step();
    step();
    alu_result_valid = 1'b1;
    alu_result       = 32'd12;
    step();
    alu_result_valid = 1'b0;
    chk("x0_wren_c4", 32'(rf_write_enable), 32'd0);
    chk("x0_busy_c4", 32'(busy),            32'd1);
    step();
    chk("x0_ready_c5", 32'(instr_ready),     32'd1);
    chk("x0_wren_c5",  32'(rf_write_enable), 32'd0);

    // ---------------- timeout after 15 EXEC cycles ----------------
    issue("tmo", rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd5));
    step();
    step();
    for (int i = 0; i < 15; i++) begin
      chk("tmo_pulse_early", 32'(timeout_error),   32'd0);
      chk("tmo_base_exec",   32'(alu_base_enable), 32'd1);
      step();
    end
    chk("tmo_pulse", 32'(timeout_error),   32'd1);
    chk("tmo_ready", 32'(instr_ready),     32'd1);
    chk("tmo_wren",  32'(rf_write_enable), 32'd0);
    chk("tmo_base",  32'(alu_base_enable), 32'd0);
    step();
    chk("tmo_pulse_end", 32'(timeout_error),   32'd0);
    chk("tmo_wren_end",  32'(rf_write_enable), 32'd0);

    // ---------------- valid on the 15th EXEC cycle wins ----------------
    issue("vwin", rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd9));
    step();
    step();
    for (int i = 0; i < 14; i++) step();
    chk("vwin_base_c17", 32'(alu_base_enable), 32'd1);
    alu_result_valid = 1'b1;
    alu_result       = 32'h123;
    step();
    alu_result_valid = 1'b0;
    chk("vwin_wren", 32'(rf_write_enable), 32'd1);
    chk("vwin_data", rf_rd_data,           32'h123);
    chk("vwin_tmo",  32'(timeout_error),   32'd0);
    step();

    // ---------------- reset in EXEC, then a clean ADD ----------------
    issue("rmid", rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd6));
    step();
    step();
    chk("rmid_base_pre", 32'(alu_base_enable), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("rmid_ready",  32'(instr_ready),     32'd1);
    chk("rmid_busy",   32'(busy),            32'd0);
    chk("rmid_base",   32'(alu_base_enable), 32'd0);
    chk("rmid_opa",    alu_operand_a,        32'd0);
    chk("rmid_rs1",    32'(rf_rs1_addr),     32'd0);
    chk("rmid_rdaddr", 32'(rf_rd_addr),      32'd0);
    #1 reset_n = 1'b1;
    step();
    chk("rmid_wren_after", 32'(rf_write_enable), 32'd0);
    issue("radd", rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd7));
    chk("radd_rden", 32'(rf_read_enable), 32'd1);
    step();
    step();
    chk("radd_opb", alu_operand_b, 32'd7);
    alu_result_valid = 1'b1;
    alu_result       = 32'd12;
    step();
    alu_result_valid = 1'b0;
    chk("radd_wren", 32'(rf_write_enable), 32'd1);
    chk("radd_rd",   32'(rf_rd_addr),      32'd7);
    chk("radd_data", rf_rd_data,           32'd12);
    step();

    // ---------------- funct7 = 0x01 ----------------
    issue("f7", rtype(7'h01, 5'd2, 5'd1, 3'b000, 5'd8));
`ifdef ALU_RR_ILLEGAL_TRAP_EN
    chk("ill_pulse",   32'(illegal_instr),  32'd1);
    chk("ill_rden",    32'(rf_read_enable), 32'd0);
    step();
    chk("ill_pulse_end", 32'(illegal_instr),   32'd0);
    chk("ill_ready",     32'(instr_ready),     32'd1);
    chk("ill_wren",      32'(rf_write_enable), 32'd0);
    step();
    chk("ill_base",      32'(alu_base_enable), 32'd0);
    chk("ill_wren2",     32'(rf_write_enable), 32'd0);
`else
    chk("f7_rden", 32'(rf_read_enable), 32'd1);
    chk("f7_ill",  32'(illegal_instr),  32'd0);
    step();
    step();
    chk("f7_base",  32'(alu_base_enable),  32'd1);
    chk("f7_extra", 32'(alu_extra_enable), 32'd0);
    alu_result_valid = 1'b1;
    alu_result       = 32'd12;
    step();
    alu_result_valid = 1'b0;
    chk("f7_wren", 32'(rf_write_enable), 32'd1);
    chk("f7_rd",   32'(rf_rd_addr),      32'd8);
`endif
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
